// File: rtl/simple_cpu_hs.sv
// Multi-cycle memory-to-memory CPU (ADD/NAND/SRL/LT/CP/CPI/BZJ/MUL, optional immediate B).
// Every RAM access is a registered request held stable until mem_ack_i, so any memory latency works.
module simple_cpu_hs #(
    parameter int                ADDR_W  = 10,
    parameter int                FIELD_W = 14,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] RST_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              halted_o,
    output logic [ADDR_W-1:0] pc_dbg_o
);
    typedef enum logic [2:0] {FETCH, LDA, LDB, EXEC, IND, WB} state_e;

    localparam logic [2:0] OP_ADD = 3'd0, OP_NAND = 3'd1, OP_SRL = 3'd2, OP_LT  = 3'd3,
                           OP_CP  = 3'd4, OP_CPI  = 3'd5, OP_BZJ = 3'd6, OP_MUL = 3'd7;
    localparam logic [DATA_W-1:0] SH_SPLIT = DATA_W'(32);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, a_q, a_d, wba_q, wba_d, addr_q, addr_d;
    logic [FIELD_W-1:0]  b_q, b_d;
    logic [2:0]          op_q, op_d;
    logic                i_q, i_d, req_q, req_d, we_q, we_d, halted_q, halted_d;
    logic [DATA_W-1:0]   ra_q, ra_d, rb_q, rb_d, res_q, res_d, wdata_q, wdata_d;
    logic [DATA_W-1:0]   imm, y;
    logic                ack;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        i_d      = i_q;
        a_d      = a_q;
        b_d      = b_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        res_d    = res_q;
        wba_d    = wba_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack      = req_q && mem_ack_i;
        imm      = {{(DATA_W-FIELD_W){1'b0}}, b_q};
        y        = i_q ? imm : rb_q;
        if (ack) req_d = 1'b0;

        case (state_q)
            FETCH: begin
                if (ack) begin
                    op_d    = mem_rdata_i[2*FIELD_W+3:2*FIELD_W+1];
                    i_d     = mem_rdata_i[2*FIELD_W];
                    a_d     = mem_rdata_i[FIELD_W+ADDR_W-1:FIELD_W];
                    b_d     = mem_rdata_i[FIELD_W-1:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = LDA;
                end else if (!req_q && run_i) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end
            end
            LDA: begin
                if (ack) begin
                    ra_d    = mem_rdata_i;
                    state_d = (!i_q || op_q == OP_CPI) ? LDB : EXEC;
                end else if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = a_q;
                end
            end
            LDB: begin
                if (ack) begin
                    rb_d    = mem_rdata_i;
                    state_d = EXEC;
                end else if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = b_q[ADDR_W-1:0];
                end
            end
            EXEC: begin
                state_d = WB;
                wba_d   = a_q;
                case (op_q)
                    OP_ADD:  res_d = ra_q + y;
                    OP_NAND: res_d = ~(ra_q & y);
                    OP_SRL:  res_d = (y < SH_SPLIT) ? (ra_q >> y) : (ra_q << (y - SH_SPLIT));
                    OP_LT:   res_d = {{(DATA_W-1){1'b0}}, (ra_q < y)};
                    OP_CP:   res_d = y;
                    OP_MUL:  res_d = ra_q * y;
                    OP_CPI: begin
                        // i=0 needs one more read (*(*B)); i=1 writes through the pointer in rA
                        if (!i_q) begin
                            state_d = IND;
                        end else begin
                            wba_d = ra_q[ADDR_W-1:0];
                            res_d = rb_q;
                        end
                    end
                    OP_BZJ: begin
                        state_d = FETCH;
                        if (i_q)             pc_d = ra_q[ADDR_W-1:0] + b_q[ADDR_W-1:0];
                        else if (rb_q == '0) pc_d = ra_q[ADDR_W-1:0];
                    end
                    default: state_d = FETCH;
                endcase
            end
            IND: begin
                if (ack) begin
                    res_d   = mem_rdata_i;
                    wba_d   = a_q;
                    state_d = WB;
                end else if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = rb_q[ADDR_W-1:0];
                end
            end
            WB: begin
                if (ack) begin
                    state_d = FETCH;
                end else if (!req_q) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = wba_q;
                    wdata_d = res_q;
                end
            end
            default: state_d = FETCH;
        endcase

        halted_d = (state_d == FETCH) && !req_d && !run_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RST_PC;
            op_q     <= '0;
            i_q      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            res_q    <= '0;
            wba_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            i_q      <= i_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            res_q    <= res_d;
            wba_q    <= wba_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign halted_o    = halted_q;
    assign pc_dbg_o    = pc_q;

endmodule

// File: tb/tb_simple_cpu_hs.sv
// Directed bench for simple_cpu_hs: behavioural RAM with optional random ack delay,
// handshake stability monitor, and hand-computed results per instruction.
module tb_simple_cpu_hs;
    localparam logic [2:0] ADD = 3'd0, NAND = 3'd1, SRL = 3'd2, LT = 3'd3,
                           CP  = 3'd4, CPI  = 3'd5, BZJ = 3'd6, MUL = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        mem_req, mem_we, mem_ack, halted;
    logic [9:0]  mem_addr, pc_dbg;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:1023] = '{default: 32'h0};
    int          wait_cnt = 0, cur_dly = 0, cyc = 0;
    bit          rand_dly = 0, ack_hold = 0, ack_force = 0;
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          errors = 0, checks = 0, stab_viol = 0;
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [9:0]  p_addr = '0;
    logic [31:0] p_wd = '0;

    simple_cpu_hs #(.ADDR_W(10), .FIELD_W(14), .DATA_W(32), .RST_PC(10'd0)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .halted_o(halted), .pc_dbg_o(pc_dbg)
    );

    always #5 clk = ~clk;

    assign mem_ack   = ack_force | (mem_req && !ack_hold && (wait_cnt >= cur_dly));
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_we) mem[pl_addr] <= pl_data;
        if (mem_req && mem_ack) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            wait_cnt <= 0;
            cur_dly  <= rand_dly ? int'($urandom_range(0, 5)) : 0;
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // A waiting request must hold its fields; an acked request must drop next cycle.
    always @(negedge clk) begin
        if (rst_n && p_req) begin
            if (!p_ack && (!mem_req || mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wd))
                stab_viol <= stab_viol + 1;
            if (p_ack && mem_req)
                stab_viol <= stab_viol + 1;
        end
        p_req  <= mem_req && rst_n;
        p_ack  <= mem_req && mem_ack;
        p_we   <= mem_we;
        p_addr <= mem_addr;
        p_wd   <= mem_wdata;
    end

    function automatic logic [31:0] enc(input logic [2:0] op, input logic i,
                                        input logic [13:0] a, input logic [13:0] b);
        return {op, i, a, b};
    endfunction

    task automatic poke(input logic [9:0] ad, input logic [31:0] d);
        pl_addr = ad; pl_data = d; pl_we = 1'b1;
        @(posedge clk); #1 pl_we = 1'b0;
    endtask

    // Start one instruction, then close the run gate; returns edges from fetch issue to halted.
    task automatic run_one(output int n, output bit ok);
        ok = 0; n = 0; run = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (mem_req) begin ok = 1; break; end
        end
        run = 1'b0;
        if (ok) begin
            ok = 0;
            for (int k = 1; k < 300; k++) begin
                @(posedge clk); #1;
                if (halted) begin ok = 1; n = k; break; end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rst_halted got %b want 1", halted); end
        checks++; if (pc_dbg !== 10'd0) begin errors++; $display("FAIL rst_pc got %h want 0", pc_dbg); end
        run = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_image;
        poke(10'd0,    enc(ADD,  1'b0, 14'd100,  14'd101));
        poke(10'd1,    enc(ADD,  1'b1, 14'd102,  14'd3));
        poke(10'd2,    enc(BZJ,  1'b1, 14'd1000, 14'd3));
        poke(10'd3,    enc(SRL,  1'b0, 14'd110,  14'd111));
        poke(10'd4,    enc(LT,   1'b0, 14'd112,  14'd113));
        poke(10'd5,    enc(MUL,  1'b0, 14'd114,  14'd115));
        poke(10'd6,    enc(NAND, 1'b1, 14'd116,  14'h0FF0));
        poke(10'd7,    enc(SRL,  1'b1, 14'd50,   14'd33));
        poke(10'd8,    enc(LT,   1'b0, 14'd60,   14'd61));
        poke(10'd9,    enc(MUL,  1'b0, 14'd62,   14'd63));
        poke(10'd10,   enc(CP,   1'b1, 14'd66,   14'h1234));
        poke(10'd11,   enc(CPI,  1'b0, 14'd70,   14'd200));
        poke(10'd12,   enc(CPI,  1'b1, 14'd71,   14'd72));
        poke(10'd13,   enc(BZJ,  1'b0, 14'd73,   14'd74));
        poke(10'd40,   enc(BZJ,  1'b0, 14'd75,   14'd76));
        poke(10'd41,   enc(BZJ,  1'b1, 14'd1000, 14'd1023));
        poke(10'd1023, enc(ADD,  1'b1, 14'd80,   14'd1));
        poke(10'd100, 32'd7);          poke(10'd101, 32'd5);
        poke(10'd102, 32'd10);         poke(10'd1000, 32'd0);
        poke(10'd110, 32'h8000_0000);  poke(10'd111, 32'd4);
        poke(10'd112, 32'd5);          poke(10'd113, 32'd9);
        poke(10'd114, 32'd1234);       poke(10'd115, 32'd5678);
        poke(10'd116, 32'hF0F0_F0F0);  poke(10'd50, 32'd1);
        poke(10'd60, 32'd3);           poke(10'd61, 32'd3);
        poke(10'd62, 32'hFFFF_FFFF);   poke(10'd63, 32'd2);
        poke(10'd200, 32'd220);        poke(10'd220, 32'h0000_ABCD);
        poke(10'd71, 32'd30);          poke(10'd72, 32'd9);
        poke(10'd73, 32'd40);          poke(10'd74, 32'd0);
        poke(10'd75, 32'd5);           poke(10'd76, 32'd1);
        poke(10'd80, 32'd0);
    endtask

    task automatic test_reset_mid_lda;
        bit seen;
        seen = 0; run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (mem_req && !mem_we && mem_addr == 10'd100) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_lda_reach got timeout want LDA req at 100"); end
        ack_hold = 1'b1; run = 1'b0; rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", mem_req); end
        checks++; if (pc_dbg !== 10'd0) begin errors++; $display("FAIL mid_rst_pc got %h want 0", pc_dbg); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL mid_rst_halted got %b want 1", halted); end
        @(posedge clk); #1;
        rst_n = 1'b1; ack_hold = 1'b0; ack_force = 1'b1;
        @(posedge clk); #1;
        ack_force = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL late_ack_req got %b want 0", mem_req); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL late_ack_halted got %b want 1", halted); end
        checks++; if (pc_dbg !== 10'd0) begin errors++; $display("FAIL late_ack_pc got %h want 0", pc_dbg); end
    endtask

    task automatic test_add;
        int c0, c1, c2;
        logic [9:0] a0;
        c0 = -1; c1 = -1; c2 = -1; a0 = 10'h3FF;
        run = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (c0 < 0 && mem_req && !mem_we) begin c0 = cyc; a0 = mem_addr; end
            else if (c0 >= 0 && mem_req && !mem_we && mem_addr == 10'd1) begin c1 = cyc; break; end
        end
        run = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (halted) begin c2 = cyc; break; end
        end
        checks++; if (a0 !== 10'd0) begin errors++; $display("FAIL first_fetch_addr got %h want 0", a0); end
        checks++; if (c1 - c0 != 9) begin errors++; $display("FAIL add_cycles got %0d want 9", c1 - c0); end
        // halted rises one cycle before the next fetch would issue
        checks++; if (c2 - c1 + 1 != 7) begin errors++; $display("FAIL addi_cycles got %0d want 7", c2 - c1 + 1); end
        checks++; if (mem[100] !== 32'd12) begin errors++; $display("FAIL add_result got %0d want 12", mem[100]); end
        checks++; if (mem[102] !== 32'd13) begin errors++; $display("FAIL addi_result got %0d want 13", mem[102]); end
    endtask

    task automatic test_bzji;
        int n; bit ok;
        run_one(n, ok);
        checks++; if (!ok || n + 1 != 5) begin errors++; $display("FAIL bzji_cycles got %0d ok=%0d want 5", n + 1, ok); end
        checks++; if (pc_dbg !== 10'd3) begin errors++; $display("FAIL bzji_pc got %0d want 3", pc_dbg); end
    endtask

    task automatic test_random_delay;
        int n; bit ok, all_ok;
        all_ok = 1; rand_dly = 1;
        for (int k = 0; k < 4; k++) begin
            run_one(n, ok);
            all_ok = all_ok & ok;
        end
        rand_dly = 0;
        checks++; if (!all_ok) begin errors++; $display("FAIL rand_done got timeout want halted"); end
        checks++; if (mem[110] !== 32'h0800_0000) begin errors++; $display("FAIL rand_srl got %h want 08000000", mem[110]); end
        checks++; if (mem[112] !== 32'd1) begin errors++; $display("FAIL rand_lt got %h want 1", mem[112]); end
        checks++; if (mem[114] !== 32'd7006652) begin errors++; $display("FAIL rand_mul got %0d want 7006652", mem[114]); end
        checks++; if (mem[116] !== 32'hFFFF_FF0F) begin errors++; $display("FAIL rand_nandi got %h want ffffff0f", mem[116]); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL handshake_stable got %0d want 0 violations", stab_viol); end
        checks++; if (pc_dbg !== 10'd7) begin errors++; $display("FAIL rand_pc got %0d want 7", pc_dbg); end
    endtask

    task automatic test_ops;
        int n; bit ok, all_ok;
        all_ok = 1;
        for (int k = 0; k < 4; k++) begin
            run_one(n, ok);
            all_ok = all_ok & ok;
        end
        checks++; if (!all_ok) begin errors++; $display("FAIL ops_done got timeout want halted"); end
        checks++; if (mem[50] !== 32'd2) begin errors++; $display("FAIL srli_33 got %h want 2", mem[50]); end
        checks++; if (mem[60] !== 32'd0) begin errors++; $display("FAIL lt_equal got %h want 0", mem[60]); end
        checks++; if (mem[62] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_wrap got %h want fffffffe", mem[62]); end
        checks++; if (mem[66] !== 32'h0000_1234) begin errors++; $display("FAIL cpi_imm got %h want 1234", mem[66]); end
    endtask

    task automatic test_cpi_bzj;
        int n; bit ok;
        run_one(n, ok);
        checks++; if (!ok || mem[70] !== 32'h0000_ABCD) begin errors++; $display("FAIL cpi_ind got %h want abcd", mem[70]); end
        run_one(n, ok);
        checks++; if (!ok || mem[30] !== 32'd9) begin errors++; $display("FAIL cpii_store got %h want 9", mem[30]); end
        run_one(n, ok);
        checks++; if (!ok || pc_dbg !== 10'd40) begin errors++; $display("FAIL bzj_taken got %0d want 40", pc_dbg); end
        run_one(n, ok);
        checks++; if (!ok || pc_dbg !== 10'd41) begin errors++; $display("FAIL bzj_not_taken got %0d want 41", pc_dbg); end
        run_one(n, ok);
        checks++; if (!ok || pc_dbg !== 10'd1023) begin errors++; $display("FAIL bzji_far got %0d want 1023", pc_dbg); end
    endtask

    task automatic test_wrap;
        int n; bit ok;
        run_one(n, ok);
        checks++; if (!ok || mem[80] !== 32'd1) begin errors++; $display("FAIL wrap_addi got %h want 1", mem[80]); end
        checks++; if (pc_dbg !== 10'd0) begin errors++; $display("FAIL wrap_pc got %0d want 0", pc_dbg); end
    endtask

    task automatic test_run_drop;
        bit seen, done;
        logic [9:0] fa;
        seen = 0; done = 0; fa = 10'h3FF; run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (mem_req) begin seen = 1; fa = mem_addr; break; end
        end
        checks++; if (!seen || fa !== 10'd0) begin errors++; $display("FAIL wrap_fetch_addr got %h want 0", fa); end
        repeat (3) @(posedge clk);
        #1 run = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL inflight_halted got %b want 0", halted); end
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (halted) begin done = 1; break; end
        end
        checks++; if (!done || mem[100] !== 32'd17) begin errors++; $display("FAIL drop_write got %0d want 17", mem[100]); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (halted !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL stay_halted got halted=%b req=%b want 1/0", halted, mem_req); end
        checks++; if (pc_dbg !== 10'd1) begin errors++; $display("FAIL drop_pc got %0d want 1", pc_dbg); end
    endtask

    initial begin
        test_reset;
        load_image;
        test_reset_mid_lda;
        test_add;
        test_bzji;
        test_random_delay;
        test_ops;
        test_cpi_bzj;
        test_wrap;
        test_run_drop;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
